// File: rtl/pulse_train_generator_if.sv
// Control/status bundle for pulse_train_generator: start/stop handshake,
// train programming fields and the pulse/status outputs.
interface pulse_train_generator_if #(
    parameter int N = 8,
    parameter int M = 8
) ();
    logic         ena;
    logic         start;
    logic         stop;
    logic [1:0]   mode;
    logic [N-1:0] ticks;
    logic [N-1:0] width;
    logic [M-1:0] count;
    logic         out;
    logic         period_tick;
    logic         busy;
    logic         done;

    modport master (
        output ena, start, stop, mode, ticks, width, count,
        input  out, period_tick, busy, done
    );

    modport slave (
        input  ena, start, stop, mode, ticks, width, count,
        output out, period_tick, busy, done
    );
endinterface

// File: rtl/pulse_train_generator.sv
// Programmable pulse-train source: continuous, burst or one-shot trains.
// Define PULSE_TRAIN_WIDTH_EN to honour the width field; otherwise pulses are one cycle wide.
module pulse_train_generator #(
    parameter int N = 8,
    parameter int M = 8
) (
    input logic                clk,
    input logic                rst,
    pulse_train_generator_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t       state;
    logic [N-1:0] counter;
    logic [N-1:0] period_q;
    logic [1:0]   mode_q;
    logic [M-1:0] left;
    logic         done_q;
    logic [N-1:0] width_eff;
    logic         wrap;
    logic         finite;

`ifdef PULSE_TRAIN_WIDTH_EN
    logic [N-1:0] width_q;

    always_comb begin
        width_eff = (width_q == '0) ? N'(1) : width_q;
    end
`else
    logic width_unused;
    assign width_unused = ^bus.width;

    always_comb begin
        width_eff = N'(1);
    end
`endif

    always_comb begin
        wrap   = (state == RUN) && (counter == period_q);
        finite = (mode_q == 2'd1) || (mode_q == 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= '0;
            period_q <= '0;
            mode_q   <= '0;
            left     <= '0;
            done_q   <= 1'b0;
`ifdef PULSE_TRAIN_WIDTH_EN
            width_q  <= '0;
`endif
        end else begin
            // done is a strict one-cycle pulse, so it clears even while ena is low
            done_q <= 1'b0;
            if (state == RUN && bus.stop) begin
                state   <= IDLE;
                counter <= '0;
            end else if (bus.ena) begin
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.stop) begin
                            state    <= RUN;
                            counter  <= '0;
                            period_q <= bus.ticks;
                            mode_q   <= bus.mode;
`ifdef PULSE_TRAIN_WIDTH_EN
                            width_q  <= bus.width;
`endif
                            case (bus.mode)
                                2'd1:    left <= (bus.count == '0) ? M'(1) : bus.count;
                                2'd2:    left <= M'(1);
                                default: left <= bus.count;
                            endcase
                        end
                    end
                    RUN: begin
                        if (wrap) begin
                            counter <= '0;
                            if (finite) begin
                                if (left <= M'(1)) begin
                                    state  <= IDLE;
                                    done_q <= 1'b1;
                                end else begin
                                    left <= left - M'(1);
                                end
                            end else begin
                                // reprogramming only lands on a period boundary
                                period_q <= bus.ticks;
`ifdef PULSE_TRAIN_WIDTH_EN
                                width_q  <= bus.width;
`endif
                            end
                        end else begin
                            counter <= counter + N'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.out         = (state == RUN) && (counter < width_eff);
    assign bus.period_tick = wrap;
    assign bus.busy        = (state == RUN);
    assign bus.done        = done_q;
endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench: directed test-plan scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural train model.
module tb_pulse_train_generator;
    localparam int N = 8;
    localparam int M = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic check_en;

    pulse_train_generator_if #(.N(N), .M(M)) bus ();

    pulse_train_generator #(.N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a running train is a phase within a period of m_per cycles,
    // with m_left pulses still owed for finite trains.
    int m_run, m_phase, m_per, m_w, m_left, m_fin, m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_phase = 0; m_per = 1; m_w = 0;
            m_left = 0; m_fin = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_run != 0 && bus.stop) begin
                m_run = 0;
                m_phase = 0;
            end else if (bus.ena) begin
                if (m_run == 0) begin
                    if (bus.start && !bus.stop) begin
                        m_run   = 1;
                        m_phase = 0;
                        m_per   = int'(bus.ticks) + 1;
                        m_w     = int'(bus.width);
                        m_fin   = (bus.mode == 2'd1 || bus.mode == 2'd2) ? 1 : 0;
                        m_left  = (bus.mode == 2'd2) ? 1 : ((bus.count == 0) ? 1 : int'(bus.count));
                    end
                end else if (m_phase == m_per - 1) begin
                    m_phase = 0;
                    if (m_fin != 0) begin
                        m_left = m_left - 1;
                        if (m_left <= 0) begin
                            m_run  = 0;
                            m_done = 1;
                        end
                    end else begin
                        m_per = int'(bus.ticks) + 1;
                        m_w   = int'(bus.width);
                    end
                end else begin
                    m_phase = m_phase + 1;
                end
            end
        end
    end

    function automatic int weff(input int w);
`ifdef PULSE_TRAIN_WIDTH_EN
        return (w < 1) ? 1 : w;
`else
        return 1;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_out",  {31'd0, bus.out},         {31'd0, (m_run != 0) && (m_phase < weff(m_w))});
            chk("model_tick", {31'd0, bus.period_tick}, {31'd0, (m_run != 0) && (m_phase == m_per - 1)});
            chk("model_busy", {31'd0, bus.busy},        {31'd0, m_run != 0});
            chk("model_done", {31'd0, bus.done},        {31'd0, m_done != 0});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] md, input int tk, input int wd, input int ct);
        bus.mode  = md;
        bus.ticks = N'(tk);
        bus.width = N'(wd);
        bus.count = M'(ct);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
    endtask

    logic [9:0] v_out, v_tick, v_done, v_busy;

    initial begin
        checks = 0; failures = 0; check_en = 1'b1;
        rst = 1'b1;
        bus.ena = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
        bus.mode = '0; bus.ticks = '0; bus.width = '0; bus.count = '0;
        cyc(); cyc();
        chk("reset_out",  {31'd0, bus.out},  32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;
        cyc();

        // continuous ticks=4 width=2
        launch(2'd0, 4, 2, 0);
        v_out = '0; v_tick = '0;
        for (int i = 0; i < 10; i++) begin
            v_out  = {v_out[8:0], bus.out};
            v_tick = {v_tick[8:0], bus.period_tick};
            cyc();
        end
`ifdef PULSE_TRAIN_WIDTH_EN
        chk("cont_out", {22'd0, v_out}, 32'b1100011000);
`else
        chk("cont_out", {22'd0, v_out}, 32'b1000010000);
`endif
        chk("cont_tick", {22'd0, v_tick}, 32'b0000100001);
        chk("cont_busy", {31'd0, bus.busy}, 32'd1);
        do_stop();
        chk("stop_busy", {31'd0, bus.busy}, 32'd0);
        chk("stop_out",  {31'd0, bus.out},  32'd0);
        cyc();

        // burst ticks=2 width=1 count=3
        launch(2'd1, 2, 1, 3);
        v_out = '0; v_done = '0; v_busy = '0;
        for (int i = 0; i < 10; i++) begin
            v_out  = {v_out[8:0], bus.out};
            v_done = {v_done[8:0], bus.done};
            v_busy = {v_busy[8:0], bus.busy};
            cyc();
        end
        chk("burst_out",  {22'd0, v_out},  32'b1001001000);
        chk("burst_done", {22'd0, v_done}, 32'b0000000001);
        chk("burst_busy", {22'd0, v_busy}, 32'b1111111110);
        cyc();

        // continuous ticks=4 reprogrammed to ticks=1 mid-period
        launch(2'd0, 4, 1, 0);
        v_out = '0;
        for (int i = 0; i < 10; i++) begin
            v_out = {v_out[8:0], bus.out};
            if (i == 1) bus.ticks = N'(1);
            cyc();
        end
        chk("reprog_out", {22'd0, v_out}, 32'b1000010101);
        do_stop();
        cyc();

        // ena freeze mid-pulse, then stop with ena low
        launch(2'd0, 4, 2, 0);
        bus.ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("freeze_out",  {31'd0, bus.out},         32'd1);
            chk("freeze_tick", {31'd0, bus.period_tick}, 32'd0);
        end
        bus.ena = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        bus.ena = 1'b0;
        do_stop();
        chk("stop_ena0_busy", {31'd0, bus.busy}, 32'd0);
        chk("stop_ena0_out",  {31'd0, bus.out},  32'd0);
        chk("stop_ena0_done", {31'd0, bus.done}, 32'd0);
        bus.ena = 1'b1;
        cyc();

        // one-shot ticks=3 width=6
        launch(2'd2, 3, 6, 9);
        v_out = '0; v_done = '0;
        for (int i = 0; i < 6; i++) begin
            v_out  = {v_out[8:0], bus.out};
            v_done = {v_done[8:0], bus.done};
            cyc();
        end
`ifdef PULSE_TRAIN_WIDTH_EN
        chk("oneshot_out", {22'd0, v_out}, 32'b0000111100);
`else
        chk("oneshot_out", {22'd0, v_out}, 32'b0000100000);
`endif
        chk("oneshot_done", {22'd0, v_done}, 32'b0000000010);

        // start and stop together in IDLE
        bus.start = 1'b1; bus.stop = 1'b1;
        cyc();
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("start_stop_busy", {31'd0, bus.busy}, 32'd0);
        cyc();

        // asynchronous reset mid-burst
        launch(2'd1, 3, 2, 5);
        cyc(); cyc(); cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst_out",  {31'd0, bus.out},         32'd0);
        chk("arst_busy", {31'd0, bus.busy},        32'd0);
        chk("arst_tick", {31'd0, bus.period_tick}, 32'd0);
        chk("arst_done", {31'd0, bus.done},        32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        launch(2'd1, 1, 3, 2);
        chk("fresh_busy", {31'd0, bus.busy}, 32'd1);
        chk("fresh_out",  {31'd0, bus.out},  32'd1);
        for (int i = 0; i < 6; i++) cyc();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.ena   = ($urandom_range(0, 9) != 0);
            bus.start = ($urandom_range(0, 4) == 0);
            bus.stop  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.mode  = 2'($urandom_range(0, 3));
                bus.ticks = N'($urandom_range(0, 7));
                bus.width = N'($urandom_range(0, 9));
                bus.count = M'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 499) == 0) begin
                bus.ticks = N'(255);
            end
            cyc();
        end

        bus.start = 1'b0; bus.stop = 1'b0; bus.ena = 1'b1;
        cyc();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
